carry_bypass_adder_32: RTL and testbench

//   Signed two's-complement adder using carry-bypass (carry-skip) blocks.

---
 rtl/carry_bypass_adder_32.sv | 117 +++++++++++
 tb/tb_carry_bypass_adder_32.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/carry_bypass_adder_32.sv
// ---------------------------------------------------------------------------
// carry_bypass_adder_32
//   Signed two's-complement adder built from carry-bypass (carry-skip) blocks.
//   Each BLOCK-bit group ripples its carry internally. When every bit of a
//   group propagates, the group's carry-in is forwarded straight to its
//   carry-out, so the carry does not walk the ripple chain.
//   Sum, unsigned carry-out and signed overflow are registered once:
//   latency 1 cycle, one result per cycle, no enable and no handshake.
//
// Parameters
//   WIDTH  operand/sum width in bits; must be a multiple of BLOCK
//   BLOCK  bits per bypass block, 2..WIDTH
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous active-high reset, clears all outputs
//   a         in   WIDTH  signed addend
//   b         in   WIDTH  signed addend
//   cin       in   1      carry into bit 0
//   sum       out  WIDTH  registered a+b+cin mod 2^WIDTH (or saturated)
//   cout      out  1      registered carry out of the MSB
//   overflow  out  1      registered signed overflow of the raw addition
//
// Configuration
//   CBA_SATURATE_EN  when defined, a signed overflow clamps the registered
//                    sum to the most positive or most negative value.
//                    cout and overflow always describe the raw addition.
//                    When undefined, the sum wraps modulo 2^WIDTH.
// ---------------------------------------------------------------------------
module carry_bypass_adder_32 #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NBLK = WIDTH / BLOCK;

    // Refuse to build a partial last block or a degenerate block size.
    generate
        if ((BLOCK < 2) || (BLOCK > WIDTH) || ((WIDTH % BLOCK) != 0)) begin : g_bad_cfg
            $error("carry_bypass_adder_32: WIDTH must be a multiple of BLOCK and BLOCK in 2..WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] gen;
    // carry[i] is the carry into bit i; carry[WIDTH] leaves the MSB.
    logic [WIDTH:0]   carry;
    logic [NBLK-1:0]  blk_prop;
    logic [WIDTH-1:0] sum_raw;
    logic             cout_raw;
    logic             ovf_raw;
    logic [WIDTH-1:0] sum_next;

    // The whole chain lives in one combinational process so each carry is
    // computed in order from the one before it.
    always_comb begin
        prop     = a ^ b;
        gen      = a & b;
        carry    = '0;
        blk_prop = '0;
        carry[0] = cin;
        for (int k = 0; k < NBLK; k++) begin
            logic all_p;
            all_p = 1'b1;
            for (int j = 0; j < BLOCK; j++) begin
                carry[k*BLOCK + j + 1] = gen[k*BLOCK + j]
                                       | (prop[k*BLOCK + j] & carry[k*BLOCK + j]);
                all_p = all_p & prop[k*BLOCK + j];
            end
            blk_prop[k] = all_p;
            // Bypass mux: a fully propagating block hands its carry-in onward.
            // Bits inside the block still use the rippled carries for s_i.
            carry[(k+1)*BLOCK] = blk_prop[k] ? carry[k*BLOCK] : carry[(k+1)*BLOCK];
        end
    end

    assign sum_raw  = prop ^ carry[WIDTH-1:0];
    assign cout_raw = carry[WIDTH];
    // Signed overflow: carry into the sign bit disagrees with carry out of it.
    assign ovf_raw  = carry[WIDTH] ^ carry[WIDTH-1];

`ifdef CBA_SATURATE_EN
    // Overflow only happens when both operands share a sign, so a's sign
    // tells which rail to clamp to.
    always_comb begin
        sum_next = sum_raw;
        if (ovf_raw) begin
            sum_next = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign sum_next = sum_raw;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            sum      <= sum_next;
            cout     <= cout_raw;
            overflow <= ovf_raw;
        end
    end

endmodule

// File: tb/tb_carry_bypass_adder_32.sv
// ---------------------------------------------------------------------------
// tb_carry_bypass_adder_32
//   Directed checks of carry_bypass_adder_32 (WIDTH=32, BLOCK=4): reset,
//   signed overflow rails, mixed-sign sums, the full bypass chain, reset in
//   the middle of operation and a back-to-back stream against a reference.
//   Inputs change 1 time unit after a rising edge; outputs are sampled at the
//   same point, one cycle after the inputs were applied.
// ---------------------------------------------------------------------------
module tb_carry_bypass_adder_32;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int total;
    int bad;

    // expected {overflow, cout, sum} for the back-to-back stream
    logic [W+1:0] exp_q[$];

    carry_bypass_adder_32 #(.WIDTH(32), .BLOCK(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // Apply one vector and return after the edge that loads it.
    task automatic drive(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
        a   = va;
        b   = vb;
        cin = vc;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        a   = 32'h1234_5678;
        b   = 32'h7FFF_FFFF;
        cin = 1'b1;
        #2;  // before any clock edge
        total++; if (sum !== 32'h0) begin bad++; $display("FAIL reset_sum got=%h exp=%h", sum, 32'h0); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b exp=0", cout); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        // held through edges while reset stays high
        @(posedge clk); #1;
        total++; if (sum !== 32'h0) begin bad++; $display("FAIL reset_hold_sum got=%h exp=%h", sum, 32'h0); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        logic [W-1:0] exp_s;
        // max + 1
        drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
`ifdef CBA_SATURATE_EN
        exp_s = 32'h7FFF_FFFF;
`else
        exp_s = 32'h8000_0000;
`endif
        total++; if (sum !== exp_s) begin bad++; $display("FAIL pos_ovf_sum got=%h exp=%h", sum, exp_s); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL pos_ovf_cout got=%b exp=0", cout); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL pos_ovf_flag got=%b exp=1", overflow); end
        // min + -1
        drive(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
`ifdef CBA_SATURATE_EN
        exp_s = 32'h8000_0000;
`else
        exp_s = 32'h7FFF_FFFF;
`endif
        total++; if (sum !== exp_s) begin bad++; $display("FAIL neg_ovf_sum got=%h exp=%h", sum, exp_s); end
        total++; if (cout !== 1'b1) begin bad++; $display("FAIL neg_ovf_cout got=%b exp=1", cout); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL neg_ovf_flag got=%b exp=1", overflow); end
        // all-ones + all-ones + 1
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        total++; if (sum !== 32'hFFFF_FFFF) begin bad++; $display("FAIL ones_cin_sum got=%h exp=ffffffff", sum); end
        total++; if (cout !== 1'b1) begin bad++; $display("FAIL ones_cin_cout got=%b exp=1", cout); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ones_cin_ovf got=%b exp=0", overflow); end
    endtask

    task automatic test_mixed();
        logic signed [W-1:0] va [6];
        logic signed [W-1:0] vb [6];
        logic signed [W-1:0] vs [6];
        logic                vco[6];
        va[0] = 52;      vb[0] = -31;    vs[0] = 21;      vco[0] = 1'b1;
        va[1] = 152;     vb[1] = 2539;   vs[1] = 2691;    vco[1] = 1'b0;
        va[2] = -495955; vb[2] = -4548;  vs[2] = -500503; vco[2] = 1'b1;
        va[3] = -451;    vb[3] = 4498;   vs[3] = 4047;    vco[3] = 1'b1;
        va[4] = 4561;    vb[4] = -89;    vs[4] = 4472;    vco[4] = 1'b1;
        va[5] = 0;       vb[5] = 0;      vs[5] = 0;       vco[5] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(va[i], vb[i], 1'b0);
            total++; if (sum !== vs[i]) begin bad++; $display("FAIL mixed%0d_sum got=%0d exp=%0d", i, $signed(sum), vs[i]); end
            total++; if (cout !== vco[i]) begin bad++; $display("FAIL mixed%0d_cout got=%b exp=%b", i, cout, vco[i]); end
            total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mixed%0d_ovf got=%b exp=0", i, overflow); end
        end
    endtask

    task automatic test_bypass();
        drive(32'h5555_5555, 32'hAAAA_AAAA, 1'b1);
        total++; if (sum !== 32'h0) begin bad++; $display("FAIL bypass_c1_sum got=%h exp=00000000", sum); end
        total++; if (cout !== 1'b1) begin bad++; $display("FAIL bypass_c1_cout got=%b exp=1", cout); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL bypass_c1_ovf got=%b exp=0", overflow); end
        drive(32'h5555_5555, 32'hAAAA_AAAA, 1'b0);
        total++; if (sum !== 32'hFFFF_FFFF) begin bad++; $display("FAIL bypass_c0_sum got=%h exp=ffffffff", sum); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL bypass_c0_cout got=%b exp=0", cout); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL bypass_c0_ovf got=%b exp=0", overflow); end
        // a single block fully propagating with carry-in from below
        drive(32'h0000_00F1, 32'h0000_000F, 1'b0);
        total++; if (sum !== 32'h0000_0100) begin bad++; $display("FAIL skip_one_sum got=%h exp=00000100", sum); end
    endtask

    task automatic test_reset_mid();
        drive(32'h0000_1000, 32'h0000_0234, 1'b0);
        total++; if (sum !== 32'h0000_1234) begin bad++; $display("FAIL pre_rst_sum got=%h exp=00001234", sum); end
        a = 32'h7FFF_FFFF; b = 32'h7FFF_FFFF; cin = 1'b1;
        #2 rst = 1'b1;
        #1;
        total++; if (sum !== 32'h0) begin bad++; $display("FAIL mid_rst_sum got=%h exp=00000000", sum); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mid_rst_ovf got=%b exp=0", overflow); end
        @(posedge clk); #1;
        total++; if (sum !== 32'h0) begin bad++; $display("FAIL mid_rst_hold got=%h exp=00000000", sum); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (sum !== 32'hFFFF_FFFF) begin bad++; $display("FAIL post_rst_sum got=%h exp=ffffffff", sum); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL post_rst_ovf got=%b exp=1", overflow); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL post_rst_cout got=%b exp=0", cout); end
    endtask

    task automatic test_back_to_back();
        logic [W:0]   full;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic         ovf;
        logic [W-1:0] es;
        logic [W+1:0] got;
        logic [W+1:0] exp;
        exp_q.delete();
        for (int n = 0; n <= 10000; n++) begin
            if (n > 0) begin
                got = {overflow, cout, sum};
                exp = exp_q.pop_front();
                total++;
                if (got !== exp) begin
                    bad++;
                    $display("FAIL b2b_vec%0d got=%h exp=%h", n - 1, got, exp);
                end
            end
            if (n < 10000) begin
                case (n % 4)
                    0: begin ra = $urandom; rb = $urandom; end
                    1: begin ra = $urandom; rb = ~ra; end
                    2: begin ra = {$urandom_range(1, 0) == 1 ? 1'b1 : 1'b0, 31'h7FFF_FFF0}; rb = {ra[31], 31'($urandom_range(255, 0))}; end
                    default: begin ra = $urandom; rb = $urandom; end
                endcase
                rc   = ($urandom_range(1, 0) == 1);
                full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
                ovf  = (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]);
                es   = full[W-1:0];
`ifdef CBA_SATURATE_EN
                if (ovf) es = ra[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
                exp_q.push_back({ovf, full[W], es});
                a = ra; b = rb; cin = rc;
            end
            @(posedge clk); #1;
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_queue got=%0d exp=0", exp_q.size()); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        test_reset();
        test_overflow();
        test_mixed();
        test_bypass();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
